// File: rtl/control_decode_pkg.sv
// Shared encodings and the registered control word for the RV32I main control decoder.
package control_decode_pkg;

  typedef enum logic [1:0] {
    ImmI   = 2'b00,
    ImmS   = 2'b01,
    ImmU   = 2'b10,
    ImmRsv = 2'b11
  } imm_sel_e;

  typedef enum logic [1:0] {
    OpARs1  = 2'b00,
    OpAPc4  = 2'b01,
    OpAPc   = 2'b10,
    OpAZero = 2'b11
  } op_a_e;

  typedef enum logic [1:0] {
    NpcPlus4  = 2'b00,
    NpcBranch = 2'b01,
    NpcJal    = 2'b10,
    NpcJalr   = 2'b11
  } next_pc_e;

  localparam logic [2:0] AluR   = 3'b000;
  localparam logic [2:0] AluI   = 3'b001;
  localparam logic [2:0] AluB   = 3'b010;
  localparam logic [2:0] AluJ   = 3'b011;
  localparam logic [2:0] AluL   = 3'b100;
  localparam logic [2:0] AluS   = 3'b101;
  localparam logic [2:0] AluLui = 3'b110;
  localparam logic [2:0] AluAui = 3'b111;

  localparam logic [3:0] ClsNop = 4'd0;
  localparam logic [3:0] ClsR   = 4'd1;
  localparam logic [3:0] ClsI   = 4'd2;
  localparam logic [3:0] ClsL   = 4'd3;
  localparam logic [3:0] ClsS   = 4'd4;
  localparam logic [3:0] ClsB   = 4'd5;
  localparam logic [3:0] ClsJ   = 4'd6;
  localparam logic [3:0] ClsJr  = 4'd7;
  localparam logic [3:0] ClsLui = 4'd8;
  localparam logic [3:0] ClsAui = 4'd9;

  typedef struct packed {
    logic       reg_write;
    logic       branch;
    logic       op_b;
    logic       store;
    logic       mem_to_reg;
    imm_sel_e   imm_sel;
    op_a_e      op_a;
    next_pc_e   next_pc;
    logic [2:0] alu;
    logic [3:0] alu_sel;
  } ctrl_t;

  localparam ctrl_t CtrlNop = '{
    reg_write:  1'b0,
    branch:     1'b0,
    op_b:       1'b0,
    store:      1'b0,
    mem_to_reg: 1'b0,
    imm_sel:    ImmI,
    op_a:       OpARs1,
    next_pc:    NpcPlus4,
    alu:        AluR,
    alu_sel:    ClsNop
  };

endpackage

// File: rtl/control_decode_comb.sv
// Combinational priority decoder: instruction-class flags to control word.
module control_decode_comb
  import control_decode_pkg::*;
(
  input  logic  R,
  input  logic  I,
  input  logic  L,
  input  logic  S,
  input  logic  B,
  input  logic  J,
  input  logic  Jr,
  input  logic  lui,
  input  logic  aui,
  output ctrl_t ctrl
);

  // Priority: lui > aui > Jr > J > B > S > L > I > R.
  always_comb begin
    ctrl = CtrlNop;
    if (lui) begin
      ctrl.reg_write = 1'b1;
      ctrl.op_a      = OpAZero;
      ctrl.op_b      = 1'b1;
      ctrl.imm_sel   = ImmU;
      ctrl.alu       = AluLui;
      ctrl.alu_sel   = ClsLui;
    end else if (aui) begin
      ctrl.reg_write = 1'b1;
      ctrl.op_a      = OpAPc;
      ctrl.op_b      = 1'b1;
      ctrl.imm_sel   = ImmU;
      ctrl.alu       = AluAui;
      ctrl.alu_sel   = ClsAui;
    end else if (Jr) begin
      ctrl.reg_write = 1'b1;
      ctrl.op_a      = OpAPc4;
      ctrl.next_pc   = NpcJalr;
      ctrl.alu       = AluJ;
      ctrl.alu_sel   = ClsJr;
    end else if (J) begin
      ctrl.reg_write = 1'b1;
      ctrl.op_a      = OpAPc4;
      ctrl.next_pc   = NpcJal;
      ctrl.alu       = AluJ;
      ctrl.alu_sel   = ClsJ;
    end else if (B) begin
      ctrl.branch    = 1'b1;
      ctrl.next_pc   = NpcBranch;
      ctrl.alu       = AluB;
      ctrl.alu_sel   = ClsB;
    end else if (S) begin
      ctrl.store     = 1'b1;
      ctrl.op_b      = 1'b1;
      ctrl.imm_sel   = ImmS;
      ctrl.alu       = AluS;
      ctrl.alu_sel   = ClsS;
    end else if (L) begin
      ctrl.reg_write  = 1'b1;
      ctrl.op_b       = 1'b1;
      ctrl.mem_to_reg = 1'b1;
      ctrl.imm_sel    = ImmI;
      ctrl.alu        = AluL;
      ctrl.alu_sel    = ClsL;
    end else if (I) begin
      ctrl.reg_write = 1'b1;
      ctrl.op_b      = 1'b1;
      ctrl.imm_sel   = ImmI;
      ctrl.alu       = AluI;
      ctrl.alu_sel   = ClsI;
    end else if (R) begin
      ctrl.reg_write = 1'b1;
      ctrl.alu       = AluR;
      ctrl.alu_sel   = ClsR;
    end
  end

endmodule

// File: rtl/control_decode.sv
// Registered main control decoder. Define CONTROL_DECODE_ILLEGAL_EN to add the
// registered multi-flag `illegal` output.
module control_decode
  import control_decode_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       R,
  input  logic       I,
  input  logic       L,
  input  logic       S,
  input  logic       B,
  input  logic       J,
  input  logic       Jr,
  input  logic       lui,
  input  logic       aui,
  output logic       regWrite,
  output logic       branch,
  output logic       opB,
  output logic       store,
  output logic       memToReg,
  output logic [1:0] immSel,
  output logic [1:0] opA,
  output logic [1:0] nextPc,
  output logic [2:0] alu,
`ifdef CONTROL_DECODE_ILLEGAL_EN
  output logic [3:0] aluSel,
  output logic       illegal
`else
  output logic [3:0] aluSel
`endif
);

  ctrl_t ctrl_d, ctrl_q;

  control_decode_comb u_comb (
    .R    (R),
    .I    (I),
    .L    (L),
    .S    (S),
    .B    (B),
    .J    (J),
    .Jr   (Jr),
    .lui  (lui),
    .aui  (aui),
    .ctrl (ctrl_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) ctrl_q <= CtrlNop;
    else        ctrl_q <= ctrl_d;
  end

  assign regWrite = ctrl_q.reg_write;
  assign branch   = ctrl_q.branch;
  assign opB      = ctrl_q.op_b;
  assign store    = ctrl_q.store;
  assign memToReg = ctrl_q.mem_to_reg;
  assign immSel   = ctrl_q.imm_sel;
  assign opA      = ctrl_q.op_a;
  assign nextPc   = ctrl_q.next_pc;
  assign alu      = ctrl_q.alu;
  assign aluSel   = ctrl_q.alu_sel;

`ifdef CONTROL_DECODE_ILLEGAL_EN
  logic [8:0] flags;
  logic       multi_d, illegal_q;

  assign flags   = {aui, lui, Jr, J, B, S, L, I, R};
  // More than one bit set iff clearing the lowest set bit leaves something.
  assign multi_d = |(flags & (flags - 9'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= multi_d;
  end

  assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_control_decode.sv
// Randomized self-checking bench for control_decode against a table-driven model.
module tb_control_decode;

  logic clk = 1'b0;
  logic rst_n;
  logic R, I, L, S, B, J, Jr, lui, aui;
  logic       regWrite, branch, opB, store, memToReg;
  logic [1:0] immSel, opA, nextPc;
  logic [2:0] alu;
  logic [3:0] aluSel;
`ifdef CONTROL_DECODE_ILLEGAL_EN
  logic       illegal;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  control_decode dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .R        (R),
    .I        (I),
    .L        (L),
    .S        (S),
    .B        (B),
    .J        (J),
    .Jr       (Jr),
    .lui      (lui),
    .aui      (aui),
    .regWrite (regWrite),
    .branch   (branch),
    .opB      (opB),
    .store    (store),
    .memToReg (memToReg),
    .immSel   (immSel),
    .opA      (opA),
    .nextPc   (nextPc),
    .alu      (alu),
`ifdef CONTROL_DECODE_ILLEGAL_EN
    .aluSel   (aluSel),
    .illegal  (illegal)
`else
    .aluSel   (aluSel)
`endif
  );

  // Flag vector bit order: 0=R 1=I 2=L 3=S 4=B 5=J 6=Jr 7=lui 8=aui
  localparam int FR = 0, FI = 1, FL = 2, FS = 3, FB = 4, FJ = 5, FJR = 6, FLUI = 7, FAUI = 8;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word layout: {regWrite,branch,opB,store,memToReg,immSel,opA,nextPc,alu,aluSel}
  function automatic logic [17:0] mk(input bit rw, input bit br, input bit ob, input bit st,
                                     input bit m2r, input logic [1:0] imm, input logic [1:0] oa,
                                     input logic [1:0] np, input logic [2:0] a,
                                     input logic [3:0] sel);
    return {rw, br, ob, st, m2r, imm, oa, np, a, sel};
  endfunction

  // Control word for a class, straight from the class table.
  function automatic logic [17:0] class_word(input int f);
    case (f)
      FR:   return mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd1);
      FI:   return mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 4'd2);
      FL:   return mk(1, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 3'b100, 4'd3);
      FS:   return mk(0, 0, 1, 1, 0, 2'b01, 2'b00, 2'b00, 3'b101, 4'd4);
      FB:   return mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 3'b010, 4'd5);
      FJ:   return mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b011, 4'd6);
      FJR:  return mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b11, 3'b011, 4'd7);
      FLUI: return mk(1, 0, 1, 0, 0, 2'b10, 2'b11, 2'b00, 3'b110, 4'd8);
      FAUI: return mk(1, 0, 1, 0, 0, 2'b10, 2'b10, 2'b00, 3'b111, 4'd9);
      default: return '0;
    endcase
  endfunction

  function automatic logic [17:0] model_word(input logic [8:0] fl, input bit rst);
    int prio[9] = '{FLUI, FAUI, FJR, FJ, FB, FS, FL, FI, FR};
    if (rst) return '0;
    foreach (prio[k]) if (fl[prio[k]]) return class_word(prio[k]);
    return '0;
  endfunction

  task automatic step(input string tag, input logic [8:0] fl, input bit rst);
    int ones;
    {aui, lui, Jr, J, B, S, L, I, R} = fl;
    rst_n = ~rst;
    @(posedge clk);
    #1;
    check_val(tag, {14'd0, regWrite, branch, opB, store, memToReg, immSel, opA, nextPc, alu,
                    aluSel}, {14'd0, model_word(fl, rst)});
`ifdef CONTROL_DECODE_ILLEGAL_EN
    ones = $countones(fl);
    check_val({tag, "_illegal"}, {31'd0, illegal}, {31'd0, !rst && ones > 1});
`else
    ones = 0;
`endif
  endtask

  initial begin
    logic [8:0] fl;
    {aui, lui, Jr, J, B, S, L, I, R} = '0;
    rst_n = 1'b0;
    step("reset0", 9'h001, 1);
    step("reset1", 9'h001, 1);
    step("r_after_reset", 9'h001, 0);
    check_val("r_regwrite", {31'd0, regWrite}, 32'd1);
    step("i_one", 9'h002, 0);
    step("l_one", 9'h004, 0);
    check_val("l_memtoreg", {31'd0, memToReg}, 32'd1);
    step("s_one", 9'h008, 0);
    check_val("s_immsel", {30'd0, immSel}, 32'd1);
    step("b_one", 9'h010, 0);
    step("j_one", 9'h020, 0);
    step("jr_one", 9'h040, 0);
    check_val("jr_nextpc", {30'd0, nextPc}, 32'd3);
    step("r_lui", 9'h081, 0);
    check_val("lui_alusel", {28'd0, aluSel}, 32'd8);
    step("aui_only", 9'h100, 0);
    check_val("aui_opa", {30'd0, opA}, 32'd2);
    step("none", 9'h000, 0);
    step("b_seq", 9'h010, 0);
    step("rst_pulse", 9'h020, 1);
    step("j_resume", 9'h020, 0);
    check_val("j_nextpc", {30'd0, nextPc}, 32'd2);
    step("all_flags", 9'h1ff, 0);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: fl = 9'd1 << $urandom_range(0, 8);
        1: fl = 9'd0;
        default: fl = 9'($urandom);
      endcase
      step("random", fl, $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_decode.md
# control_decode

Main control decoder of the RV32I core. It takes one-hot instruction-class flags from the opcode decoder and produces the datapath control word:

- register-file write enable
- branch, store and load-writeback enables
- immediate selection
- ALU operand selection
- next-PC selection
- ALU operation code and class code

The control word is registered: it is presented one clock after the flags, feeding the execute stage.

## Interface

Clock is `clk`; reset is `rst_n`, synchronous and active-low. No parameters.

Ports:
- `clk` in 1 — clock, rising edge.
- `rst_n` in 1 — synchronous active-low reset.
- `R`, `I`, `L`, `S`, `B`, `J`, `Jr`, `lui`, `aui` in 1 each — instruction-class flags. The instruction classes are:
  - R-type, I-type ALU, load, store, branch
  - jal, jalr
  - lui, auipc
- `regWrite` out 1 — register-file write enable.
- `branch` out 1 — conditional-branch enable.
- `opB` out 1 — ALU operand B: 0 = rs2, 1 = immediate.
- `store` out 1 — data-memory write enable.
- `memToReg` out 1 — writeback source: 0 = ALU, 1 = memory.
- `immSel` out 2 — immediate format: 00 = I, 01 = S, 10 = U, 11 reserved.
- `opA` out 2 — ALU operand A: 00 = rs1, 01 = PC+4, 10 = PC, 11 = zero.
- `nextPc` out 2 — next PC: 00 = PC+4, 01 = branch target, 10 = jal target, 11 = jalr target.
- `alu` out 3 — ALU operation class.
- `aluSel` out 4 — decoded class index.

## Operation

The decoded class is chosen by fixed priority when several flags are high: lui > aui > Jr > J > B > S > L > I > R. If no flag is high the class is NOP.

All unlisted outputs are 0 for every class.

- **R:**
  - regWrite=1, alu=000, aluSel=1.
- **I:**
  - regWrite=1, opB=1, immSel=00, alu=001, aluSel=2.
- **L:**
  - regWrite=1, opB=1, memToReg=1, immSel=00, alu=100, aluSel=3.
- **S:**
  - store=1, opB=1, immSel=01, alu=101, aluSel=4.
- **B:**
  - branch=1, nextPc=01, alu=010, aluSel=5.
- **J:**
  - regWrite=1, opA=01, nextPc=10, alu=011, aluSel=6.
- **Jr:**
  - regWrite=1, opA=01, nextPc=11, alu=011, aluSel=7.
- **lui:**
  - regWrite=1, opA=11, opB=1, immSel=10, alu=110, aluSel=8.
- **aui:**
  - regWrite=1, opA=10, opB=1, immSel=10, alu=111, aluSel=9.
- **NOP (no flag):**
  - all outputs 0, aluSel=0.

aluSel values 10–15 are never produced.

## Timing

- All outputs are registered, with one-cycle latency: flags sampled at edge k appear on the outputs after edge k.
- Reset: when `rst_n`=0 at a rising edge, every output becomes 0 (the NOP word), regardless of the flags.
- The first decode is presented after the first edge with `rst_n`=1.
- Reset asserted mid-stream overrides the decode of that cycle.
- Decode resumes from the current flags on the first edge after deassertion.
- Flags changing every cycle produce a matching output sequence, with no stall and no handshake.
- Multiple flags high in the same cycle resolve by priority within that cycle; no state is carried between cycles.

## Configuration

- **`CONTROL_DECODE_ILLEGAL_EN` defined:** adds output `illegal` (1 bit, registered, reset 0).
  - It is 1 in the cycle after more than one flag was high.
  - The control word still follows the priority rule.
- **`CONTROL_DECODE_ILLEGAL_EN` undefined:** the port and its logic are absent, and behaviour is otherwise identical.

## Structure

- Package `control_decode_pkg` holds:
  - the immSel, opA and nextPc encodings;
  - the alu codes and the aluSel class indices;
  - a packed struct for the control word and its NOP constant.
- Sub-module `control_decode_comb` is the purely combinational priority decoder from flags to struct.
- `control_decode` wraps it with the reset-able output register, plus the optional illegal detector.

## Test plan

- Reset held low for 2 cycles with R=1 → all outputs 0. After release, the next edge gives regWrite=1, alu=000, aluSel=1.
- Sequence R, I, L, S, B, J, Jr, one flag per cycle → each output word matches its class one cycle later. For example:
  - L gives memToReg=1, opB=1, alu=100.
  - S gives store=1, immSel=01, regWrite=0.
  - Jr gives nextPc=11, opA=01.
- R=1 and lui=1 together → lui word: opA=11, opB=1, immSel=10, alu=110, aluSel=8. With the macro defined, illegal=1.
- aui alone → opA=10, opB=1, immSel=10, alu=111, aluSel=9, regWrite=1.
- All flags 0 → NOP word, aluSel=0, illegal=0.
- `rst_n` pulsed low for one cycle during a B→J sequence → outputs are 0 for that cycle, then J resumes with nextPc=10 on the next edge.
